// File: rtl/dawg_cache_ctrl.sv
// Write-back, write-allocate set-associative cache controller with DAWG way partitioning:
// a domain allocates only into its fillmap ways and hits only in its hitmap ways.
module dawg_cache_ctrl #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 1024,
  parameter int NUM_DOMAINS = 4,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  localparam int DOM_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_valid,
  input  logic                cpu_rw,
  input  logic                cpu_flush,
  input  logic [DOM_W-1:0]    cpu_domain,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [LINE_W-1:0]   cpu_wdata,
  output logic                cpu_ready,
  output logic                cpu_err,
  output logic [LINE_W-1:0]   cpu_rdata,
  output logic                cpu_busy,
  output logic                mem_valid,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                cfg_we,
  input  logic [DOM_W-1:0]    cfg_domain,
  input  logic [NUM_WAYS-1:0] cfg_fillmap,
  input  logic [NUM_WAYS-1:0] cfg_hitmap
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_e;

  state_e state_q, state_d;

  // Storage arrays and per-line metadata
  logic [LINE_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

  // Policy table and round-robin pointers, one entry per domain
  logic [NUM_WAYS-1:0] fill_map_q [NUM_DOMAINS];
  logic [NUM_WAYS-1:0] hit_map_q  [NUM_DOMAINS];
  logic [WAY_W-1:0]    rr_q       [NUM_DOMAINS];

  // Request latched at acceptance, including the policy in force at that edge
  logic                req_rw_q, req_flush_q;
  logic [DOM_W-1:0]    req_dom_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [IDX-1:0]      req_idx_q;
  logic [LINE_W-1:0]   req_wdata_q;
  logic [NUM_WAYS-1:0] req_fill_q, req_hit_q;

  logic [WAY_W-1:0]    way_q, way_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;

  logic [NUM_WAYS-1:0] hit_vec, inv_vec;
  logic                hit_any, inv_any, hit_dirty, rr_found;
  logic [WAY_W-1:0]    hit_way, inv_way, rr_way, rr_cand, victim_way;

  logic                line_we, tag_we, meta_we, meta_valid, meta_dirty, rr_we;
  logic [WAY_W-1:0]    wr_way;
  logic [LINE_W-1:0]   line_wdata;

  logic                unused_off;
  assign unused_off = ^cpu_addr[OFF-1:0];

  // Lookup of the latched set; hits are filtered by the latched hitmap
  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[w][req_idx_q] == req_tag_q) && req_hit_q[w];
      inv_vec[w] = !valid_q[req_idx_q][w] && req_fill_q[w];
    end
    hit_any = |hit_vec;
    inv_any = |inv_vec;
    hit_way = '0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
    hit_dirty = dirty_q[req_idx_q][hit_way];

    // Next fillmap way after the domain's pointer, wrapping at NUM_WAYS
    rr_cand  = rr_q[req_dom_q];
    rr_way   = rr_q[req_dom_q];
    rr_found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      rr_cand = (rr_cand == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_cand + WAY_W'(1);
      if (!rr_found && req_fill_q[rr_cand]) begin
        rr_way   = rr_cand;
        rr_found = 1'b1;
      end
    end
    victim_way = inv_any ? inv_way : rr_way;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    way_d      = way_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    wr_way     = way_q;
    line_we    = 1'b0;
    line_wdata = req_wdata_q;
    tag_we     = 1'b0;
    meta_we    = 1'b0;
    meta_valid = 1'b0;
    meta_dirty = 1'b0;
    rr_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_valid) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (req_flush_q) begin
          if (hit_any && hit_dirty) begin
            way_d   = hit_way;
            state_d = S_WRITE_BACK;
          end else begin
            wr_way  = hit_way;
            meta_we = hit_any;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (hit_any) begin
          wr_way  = hit_way;
          ready_d = 1'b1;
          state_d = S_IDLE;
          if (req_rw_q) begin
            line_we    = 1'b1;
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
          end else begin
            rdata_d = data_q[hit_way][req_idx_q];
          end
        end else if (req_fill_q == '0) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          way_d   = victim_way;
          rr_we   = !inv_any;
          state_d = dirty_q[req_idx_q][victim_way] ? S_WRITE_BACK : S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        if (mem_ready) begin
          if (req_flush_q) begin
            meta_we = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ALLOCATE;
          end
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          line_we    = 1'b1;
          tag_we     = 1'b1;
          meta_we    = 1'b1;
          meta_valid = 1'b1;
          meta_dirty = req_rw_q;
          ready_d    = 1'b1;
          state_d    = S_IDLE;
          if (!req_rw_q) begin
            line_wdata = mem_rdata;
            rdata_d    = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      way_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      req_rw_q    <= 1'b0;
      req_flush_q <= 1'b0;
      req_dom_q   <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      req_fill_q  <= '0;
      req_hit_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        fill_map_q[d] <= '1;
        hit_map_q[d]  <= '1;
        rr_q[d]       <= '0;
      end
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (state_q == S_IDLE && cpu_valid) begin
        req_rw_q    <= cpu_rw;
        req_flush_q <= cpu_flush;
        req_dom_q   <= cpu_domain;
        req_tag_q   <= cpu_addr[ADDR_W-1:OFF+IDX];
        req_idx_q   <= cpu_addr[OFF+IDX-1:OFF];
        req_wdata_q <= cpu_wdata;
        req_fill_q  <= fill_map_q[cpu_domain];
        req_hit_q   <= hit_map_q[cpu_domain];
      end
      if (cfg_we) begin
        fill_map_q[cfg_domain] <= cfg_fillmap;
        hit_map_q[cfg_domain]  <= cfg_hitmap;
      end
      if (rr_we) rr_q[req_dom_q] <= rr_way;
      if (meta_we) begin
        valid_q[req_idx_q][wr_way] <= meta_valid;
        dirty_q[req_idx_q][wr_way] <= meta_dirty;
      end
    end
  end

  // NOTE: data and tag arrays have no reset; valid bits gate every use of their contents.
  always_ff @(posedge clk) begin
    if (line_we) data_q[wr_way][req_idx_q] <= line_wdata;
    if (tag_we)  tag_q[wr_way][req_idx_q]  <= req_tag_q;
  end

  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign cpu_busy  = (state_q != S_IDLE);

  always_comb begin
    mem_valid = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_WRITE_BACK) begin
      mem_valid = 1'b1;
      mem_rw    = 1'b1;
      mem_addr  = {tag_q[way_q][req_idx_q], req_idx_q, {OFF{1'b0}}};
      mem_wdata = data_q[way_q][req_idx_q];
    end else if (state_q == S_ALLOCATE) begin
      mem_valid = 1'b1;
      mem_addr  = {req_tag_q, req_idx_q, {OFF{1'b0}}};
    end
  end

endmodule

// File: tb/tb_dawg_cache_ctrl.sv
// Scoreboard bench for dawg_cache_ctrl: stimulus pushes expected CPU responses and memory
// transactions; an independent monitor pops and compares them as the DUT presents them.
module tb_dawg_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_valid, cpu_rw, cpu_flush;
  logic [1:0]   cpu_domain;
  logic [31:0]  cpu_addr;
  logic [127:0] cpu_wdata;
  logic         cpu_ready, cpu_err, cpu_busy;
  logic [127:0] cpu_rdata;
  logic         mem_valid, mem_rw, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         cfg_we;
  logic [1:0]   cfg_domain;
  logic [3:0]   cfg_fillmap, cfg_hitmap;

  dawg_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_flush(cpu_flush), .cpu_domain(cpu_domain),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cfg_we(cfg_we), .cfg_domain(cfg_domain), .cfg_fillmap(cfg_fillmap), .cfg_hitmap(cfg_hitmap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    logic         chk_data;
    logic [127:0] data;
    int           lat;
  } cpu_exp_t;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic         chk_data;
    logic [127:0] data;
  } mem_exp_t;

  cpu_exp_t exp_cpu[$];
  mem_exp_t exp_mem[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int present_cyc = 0;
  int resp_cnt = 0;
  int want_resp = 0;
  logic mem_hold = 1'b0;

  localparam logic [127:0] D1  = 128'hD1D1_0001_D1D1_0002_D1D1_0003_D1D1_0004;
  localparam logic [127:0] D3  = 128'hD3D3_0001_D3D3_0002_D3D3_0003_D3D3_0004;
  localparam logic [127:0] D3B = 128'hB3B3_1111_B3B3_2222_B3B3_3333_B3B3_4444;
  localparam logic [127:0] D3C = 128'hC3C3_5555_C3C3_6666_C3C3_7777_C3C3_8888;
  localparam logic [127:0] D7  = 128'h7777_AAAA_7777_BBBB_7777_CCCC_7777_DDDD;

  function automatic logic [127:0] fill_data(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, 32'h0F0F_0F0F};
  endfunction

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_c(input logic err, input logic chk, input logic [127:0] data, input int lat);
    cpu_exp_t e;
    e.err = err; e.chk_data = chk; e.data = data; e.lat = lat;
    exp_cpu.push_back(e);
    want_resp++;
  endtask

  task automatic exp_m(input logic rw, input logic [31:0] addr, input logic chk, input logic [127:0] data);
    mem_exp_t e;
    e.rw = rw; e.addr = addr; e.chk_data = chk; e.data = data;
    exp_mem.push_back(e);
  endtask

  task automatic cfg(input logic [1:0] dom, input logic [3:0] fm, input logic [3:0] hm);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_domain = dom; cfg_fillmap = fm; cfg_hitmap = hm;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic req(input logic [1:0] dom, input logic rw, input logic fl,
                     input logic [31:0] addr, input logic [127:0] wd, input bit wait_resp);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = rw; cpu_flush = fl; cpu_domain = dom;
    cpu_addr = addr; cpu_wdata = wd;
    present_cyc = cyc;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    if (wait_resp) begin
      for (int n = 0; n < 60 && resp_cnt < want_resp; n++) @(negedge clk);
      if (resp_cnt < want_resp) begin
        fail_now("cpu_ready_timeout");
        resp_cnt = want_resp;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: one-cycle ack shortly after each request is seen
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_valid && !mem_hold && !rst) begin
        mem_ready = 1'b1;
        mem_rdata = fill_data(mem_addr);
      end
    end
  end

  // Monitor: compares each CPU completion and each new memory transaction with the scoreboard
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_addr  = '0;
  cpu_exp_t    ce;
  mem_exp_t    me;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (cpu_ready) begin
          resp_cnt++;
          if (exp_cpu.size() == 0) fail_now("cpu_ready_unexpected");
          else begin
            ce = exp_cpu.pop_front();
            check1("cpu_err", cpu_err, ce.err);
            if (ce.chk_data) check128("cpu_rdata", cpu_rdata, ce.data);
            if (ce.lat >= 0) check_int("cpu_latency", cyc - present_cyc, ce.lat);
          end
        end
        if (mem_valid) begin
          if (!prev_valid || prev_ready) begin
            if (exp_mem.size() == 0) begin
              $display("FAIL mem_unexpected: rw %b addr %h", mem_rw, mem_addr);
              checks++;
              errors++;
            end else begin
              me = exp_mem.pop_front();
              check1("mem_rw", mem_rw, me.rw);
              check32("mem_addr", mem_addr, me.addr);
              if (me.chk_data) check128("mem_wdata", mem_wdata, me.data);
            end
          end else begin
            check32("mem_addr_stable", mem_addr, prev_addr);
          end
        end
        prev_valid = mem_valid;
        prev_ready = mem_ready;
        prev_addr  = mem_addr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_flush = 1'b0; cpu_domain = '0;
    cpu_addr = '0; cpu_wdata = '0;
    cfg_we = 1'b0; cfg_domain = '0; cfg_fillmap = '0; cfg_hitmap = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_cpu_ready", cpu_ready, 1'b0);
    check1("rst_cpu_busy", cpu_busy, 1'b0);
    check1("rst_mem_valid", mem_valid, 1'b0);
    check128("rst_cpu_rdata", cpu_rdata, '0);
    rst = 1'b0;

    // 1: dom1 confined to way1; write miss fills, read hits with 2-cycle latency
    cfg(2'd1, 4'b0010, 4'b0010);
    exp_m(1'b0, 32'h1111_0010, 1'b0, '0);
    exp_c(1'b0, 1'b0, '0, -1);
    req(2'd1, 1'b1, 1'b0, 32'h1111_0010, D1, 1);
    exp_c(1'b0, 1'b1, D1, 2);
    req(2'd1, 1'b0, 1'b0, 32'h1111_0010, '0, 1);

    // 2: dom3 confined to way3; misses despite way1 holding the line
    cfg(2'd3, 4'b1000, 4'b1000);
    exp_m(1'b0, 32'h1111_0010, 1'b0, '0);
    exp_c(1'b0, 1'b0, '0, -1);
    req(2'd3, 1'b1, 1'b0, 32'h1111_0010, D3, 1);

    // 3: dom3 conflict evicts its own dirty way3; dom1's way1 is untouched
    exp_m(1'b1, 32'h1111_0010, 1'b1, D3);
    exp_m(1'b0, 32'h3333_0010, 1'b0, '0);
    exp_c(1'b0, 1'b0, '0, -1);
    req(2'd3, 1'b1, 1'b0, 32'h3333_0010, D3B, 1);
    exp_c(1'b0, 1'b1, D1, 2);
    req(2'd1, 1'b0, 1'b0, 32'h1111_0010, '0, 1);
    exp_c(1'b0, 1'b1, D3B, 2);
    req(2'd3, 1'b0, 1'b0, 32'h3333_0010, '0, 1);
    exp_c(1'b0, 1'b0, '0, 2);
    req(2'd3, 1'b1, 1'b0, 32'h3333_0010, D3C, 1);
    exp_c(1'b0, 1'b1, D3C, 2);
    req(2'd3, 1'b0, 1'b0, 32'h3333_0010, '0, 1);

    // 4: empty fillmap reports an error with no memory traffic
    cfg(2'd2, 4'b0000, 4'b1111);
    exp_c(1'b1, 1'b0, '0, -1);
    req(2'd2, 1'b0, 1'b0, 32'h2222_0040, '0, 1);

    // Round-robin replacement in dom0, set 0x100
    exp_m(1'b0, 32'h0000_5000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_5000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0000_5000, '0, 1);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_5000), 2);
    req(2'd0, 1'b0, 1'b0, 32'h0000_5000, '0, 1);
    exp_m(1'b0, 32'h0000_9000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_9000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0000_9000, '0, 1);
    exp_m(1'b0, 32'h0000_D000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_D000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0000_D000, '0, 1);
    exp_m(1'b0, 32'h0001_1000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0001_1000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0001_1000, '0, 1);
    exp_m(1'b0, 32'h0001_5000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0001_5000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0001_5000, '0, 1);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_5000), 2);
    req(2'd0, 1'b0, 1'b0, 32'h0000_5000, '0, 1);
    exp_m(1'b0, 32'h0000_9000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_9000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0000_9000, '0, 1);
    exp_c(1'b0, 1'b1, fill_data(32'h0001_1000), 2);
    req(2'd0, 1'b0, 1'b0, 32'h0001_1000, '0, 1);
    exp_c(1'b0, 1'b1, fill_data(32'h0001_5000), 2);
    req(2'd0, 1'b0, 1'b0, 32'h0001_5000, '0, 1);

    // 5: flush dirty line writes back once; flush of a clean line is silent
    exp_m(1'b1, 32'h1111_0010, 1'b1, D1);
    exp_c(1'b0, 1'b0, '0, -1);
    req(2'd1, 1'b0, 1'b1, 32'h1111_0010, '0, 1);
    exp_m(1'b0, 32'h1111_0010, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h1111_0010), -1);
    req(2'd1, 1'b0, 1'b0, 32'h1111_0010, '0, 1);
    exp_c(1'b0, 1'b0, '0, 2);
    req(2'd1, 1'b0, 1'b1, 32'h1111_0010, '0, 1);
    exp_m(1'b0, 32'h1111_0010, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h1111_0010), -1);
    req(2'd1, 1'b0, 1'b0, 32'h1111_0010, '0, 1);

    // 6: reset while a write-back is stalled
    exp_m(1'b0, 32'h0000_7000, 1'b0, '0);
    exp_c(1'b0, 1'b0, '0, -1);
    req(2'd0, 1'b1, 1'b0, 32'h0000_7000, D7, 1);
    mem_hold = 1'b1;
    exp_m(1'b1, 32'h0000_7000, 1'b1, D7);
    req(2'd0, 1'b0, 1'b1, 32'h0000_7000, '0, 0);
    repeat (4) @(negedge clk);
    check1("wb_stalled_valid", mem_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("rst_async_mem_valid", mem_valid, 1'b0);
    check1("rst_async_busy", cpu_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_hold = 1'b0;
    exp_m(1'b0, 32'h1111_0010, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h1111_0010), -1);
    req(2'd1, 1'b0, 1'b0, 32'h1111_0010, '0, 1);
    exp_c(1'b0, 1'b1, fill_data(32'h1111_0010), 2);
    req(2'd3, 1'b0, 1'b0, 32'h1111_0010, '0, 1);
    exp_m(1'b0, 32'h2222_0040, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h2222_0040), -1);
    req(2'd2, 1'b0, 1'b0, 32'h2222_0040, '0, 1);
    exp_m(1'b0, 32'h0000_7000, 1'b0, '0);
    exp_c(1'b0, 1'b1, fill_data(32'h0000_7000), -1);
    req(2'd0, 1'b0, 1'b0, 32'h0000_7000, '0, 1);

    repeat (6) @(negedge clk);
    check_int("cpu_queue_drained", exp_cpu.size(), 0);
    check_int("mem_queue_drained", exp_mem.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
